// File: rtl/cache_pkg.sv
// Shared widths, FSM states and array entry layout for the cache sequencer.
package cache_pkg;
  localparam int ADDR_W  = 15;
  localparam int IDX_W   = 12;
  localparam int TAG_W   = 3;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = 36;

  typedef enum logic [2:0] {
    FLUSH  = 3'd0,
    IDLE   = 3'd1,
    LOOKUP = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W];
  endfunction
endpackage

// File: rtl/cache_ctrl_rr_arb2.sv
// Two-port round-robin arbiter; pointer remembers the last accepted port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last;  // 1 = port 1 was granted most recently

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)         last <= 1'b1;
    else if (accept) last <= gnt[1];
  end
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped cache sequencer: flush sweep, arbitration, lookup, line refill, response.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  output logic [1:0]          gnt,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_hit,
  input  logic                flush,
  output logic                busy,
  output logic [IDX_W-1:0]    arr_addr,
  output logic                arr_we,
  output logic [ENTRY_W-1:0]  arr_wdata,
  input  logic [ENTRY_W-1:0]  arr_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);
  localparam int K_W = $clog2(LINE_WORDS + 1);

  state_t            state, state_nx;
  logic [IDX_W-1:0]  fidx;
  logic              sel;
  logic [ADDR_W-1:0] addr_q;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] data_q;
  logic              hit_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  logic [1:0]        arb_gnt, grant;
  logic              accept, hit, issuing, writing;
  entry_t            rd;
  logic [ADDR_W-1:0] iss_a, wr_a, gnt_a;

  logic [IDX_W-1:0]   arr_addr_c;
  logic               arr_we_c;
  logic [ENTRY_W-1:0] arr_wdata_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [1:0]         rsp_valid_c;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .gnt    (arb_gnt)
  );

  assign grant   = (state == IDLE && !flush && !rst) ? arb_gnt : 2'b00;
  assign accept  = |grant;
  assign gnt_a   = grant[1] ? addr1 : addr0;
  assign rd      = entry_t'(arr_rdata);
  assign hit     = rd.valid && (rd.tag == tag_of(addr_q));
  // Refill walks forward from the requested word, wrapping over the 15-bit space.
  assign iss_a   = addr_q + ADDR_W'(k);
  assign wr_a    = iss_a - ADDR_W'(1);
  assign issuing = (k < K_W'(LINE_WORDS));
  assign writing = (k != '0);

  always_comb begin
    state_nx    = state;
    arr_addr_c  = idx_of(addr_q);
    arr_we_c    = 1'b0;
    arr_wdata_c = '0;
    mem_addr_c  = mem_addr_q;
    rsp_valid_c = 2'b00;
    case (state)
      FLUSH: begin
        arr_we_c   = 1'b1;
        arr_addr_c = fidx;
        if (&fidx) state_nx = IDLE;
      end
      IDLE: begin
        if (flush) begin
          state_nx = FLUSH;
        end else if (accept) begin
          arr_addr_c = idx_of(gnt_a);
          state_nx   = LOOKUP;
        end
      end
      LOOKUP: state_nx = hit ? RESP : FILL;
      FILL: begin
        if (issuing) mem_addr_c = iss_a;
        if (writing) begin
          arr_we_c    = 1'b1;
          arr_addr_c  = idx_of(wr_a);
          arr_wdata_c = entry_t'{valid: 1'b1, tag: tag_of(wr_a), data: mem_rdata};
        end
        if (k == K_W'(LINE_WORDS)) state_nx = RESP;
      end
      RESP: begin
        rsp_valid_c[sel] = 1'b1;
        state_nx         = IDLE;
      end
      default: state_nx = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FLUSH;
      fidx       <= '0;
      sel        <= 1'b0;
      addr_q     <= '0;
      k          <= '0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nx;
      mem_addr_q <= mem_addr_c;
      case (state)
        FLUSH: fidx <= fidx + 1'b1;
        IDLE: begin
          fidx <= '0;
          if (accept) begin
            sel    <= grant[1];
            addr_q <= gnt_a;
          end
        end
        LOOKUP: begin
          k     <= '0;
          hit_q <= hit;
          if (hit) begin
            data_q <= rd.data;
            if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
          end else if (miss_cnt != {CNT_W{1'b1}}) begin
            miss_cnt <= miss_cnt + 1'b1;
          end
        end
        FILL: begin
          k <= k + 1'b1;
          if (k == K_W'(1)) data_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign gnt        = grant;
  assign busy       = !rst && (state != IDLE);
  assign arr_addr   = rst ? '0 : arr_addr_c;
  assign arr_we     = !rst && arr_we_c;
  assign arr_wdata  = rst ? '0 : arr_wdata_c;
  assign mem_addr   = rst ? '0 : mem_addr_c;
  assign rsp_valid  = rst ? 2'b00 : rsp_valid_c;
  assign rsp_data   = (!rst && state == RESP) ? data_q : '0;
  assign rsp_hit    = !rst && (state == RESP) && hit_q;
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with behavioural array and memory models.
module tb_cache_ctrl;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [14:0] addr0, addr1;
  logic        flush;
  logic [1:0]  gnt, rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_hit, busy;
  logic [11:0] arr_addr;
  logic        arr_we;
  logic [35:0] arr_wdata, arr_rdata;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [15:0] hit_count, miss_count;

  int nvec = 0;
  int nerr = 0;

  cache_ctrl #(.LINE_WORDS(LW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .flush(flush), .busy(busy), .arr_addr(arr_addr), .arr_we(arr_we),
    .arr_wdata(arr_wdata), .arr_rdata(arr_rdata), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [14:0] a);
    return {a[7:0] ^ 8'h5A, 2'b10, a, 7'h33};
  endfunction

  logic [35:0] arr_m [4096];
  always @(posedge clk) begin
    mem_rdata <= memf(mem_addr);
    arr_rdata <= arr_m[arr_addr];
    if (arr_we) arr_m[arr_addr] <= arr_wdata;
  end

  int          busy_cnt = 0, wz_cnt = 0, wz_err = 0, rsp_cnt = 0;
  logic [11:0] wz_next = '0;
  logic [14:0] prev_mem = '0;
  logic [11:0] fl_addr [$];
  logic [35:0] fl_data [$];
  logic [14:0] mem_log [$];

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (arr_we && arr_wdata == 36'd0) begin
      wz_cnt <= wz_cnt + 1;
      if (arr_addr != wz_next) wz_err <= wz_err + 1;
      wz_next <= arr_addr + 12'd1;
    end
    if (arr_we && arr_wdata[35]) begin
      fl_addr.push_back(arr_addr);
      fl_data.push_back(arr_wdata);
    end
    if (mem_addr != prev_mem) begin
      mem_log.push_back(mem_addr);
      prev_mem <= mem_addr;
    end
    if (rsp_valid != 2'b00) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    nvec++;
  endtask

  task automatic wait_gnt(output int n);
    #1;
    n = 0;
    while (gnt == 2'b00 && n < 10000) begin
      tick();
      n++;
    end
  endtask

  task automatic get_rsp(input int p, input logic [14:0] a, input logic exp_hit);
    int lat;
    tick();
    req[p] = 1'b0;
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 40) begin
      tick();
      lat++;
    end
    chk("rsp_latency", 64'(lat), exp_hit ? 64'd2 : 64'(3 + LW));
    chk("rsp_port", 64'(rsp_valid), (p == 1) ? 64'd2 : 64'd1);
    chk("rsp_hit", 64'(rsp_hit), 64'(exp_hit));
    chk("rsp_data", 64'(rsp_data), 64'(memf(a)));
    tick();
  endtask

  task automatic rd(input int p, input logic [14:0] a, input logic exp_hit);
    int n;
    if (p == 1) addr1 = a; else addr0 = a;
    req[p] = 1'b1;
    wait_gnt(n);
    chk("gnt", 64'(gnt), (p == 1) ? 64'd2 : 64'd1);
    get_rsp(p, a, exp_hit);
  endtask

  task automatic check_fill(input logic [14:0] a, input int f0, input int m0);
    logic [14:0] ak;
    chk("fill_writes", 64'(fl_addr.size() - f0), 64'(LW));
    chk("fill_issues", 64'(mem_log.size() - m0), 64'(LW));
    if (fl_addr.size() - f0 >= LW && mem_log.size() - m0 >= LW) begin
      for (int k = 0; k < LW; k++) begin
        ak = a + 15'(k);
        chk("fill_mem_addr", 64'(mem_log[m0 + k]), 64'(ak));
        chk("fill_arr", 64'({fl_addr[f0 + k], fl_data[f0 + k]}),
            64'({ak[11:0], 1'b1, ak[14:12], memf(ak)}));
      end
    end
  endtask

  initial begin
    int n, b0, z0, f0, m0, r0;
    rst = 1'b1; req = 2'b01; addr0 = 15'h1005; addr1 = '0; flush = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arr_we", 64'(arr_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_misses", 64'(miss_count), 64'd0);

    // post-reset sweep, then cold miss on 0x1005
    b0 = busy_cnt; z0 = wz_cnt; f0 = fl_addr.size(); m0 = mem_log.size();
    rst = 1'b0;
    wait_gnt(n);
    chk("flush_len", 64'(n), 64'd4096);
    chk("flush_busy", 64'(busy_cnt - b0), 64'd4096);
    chk("flush_writes", 64'(wz_cnt - z0), 64'd4096);
    chk("flush_order", 64'(wz_err), 64'd0);
    chk("gnt_after_flush", 64'(gnt), 64'd1);
    get_rsp(0, 15'h1005, 1'b0);
    check_fill(15'h1005, f0, m0);

    rd(0, 15'h1006, 1'b1);
    chk("hits_1", 64'(hit_count), 64'd1);
    chk("misses_1", 64'(miss_count), 64'd1);

    // tag conflict at index 5
    f0 = fl_addr.size(); m0 = mem_log.size();
    rd(1, 15'h2005, 1'b0);
    check_fill(15'h2005, f0, m0);
    rd(0, 15'h1005, 1'b0);
    chk("hits_2", 64'(hit_count), 64'd1);
    chk("misses_2", 64'(miss_count), 64'd3);

    // both ports pending; port 0 was granted last
    addr0 = 15'h1006; addr1 = 15'h1007; req = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] eg;
      eg = (t % 2 == 0) ? 2'b10 : 2'b01;
      n = 0;
      while (gnt == 2'b00 && n < 50) begin tick(); n++; end
      chk("arb_gnt", 64'(gnt), 64'(eg));
      tick();
      n = 1;
      while (rsp_valid == 2'b00 && n < 50) begin tick(); n++; end
      chk("arb_lat", 64'(n), 64'd2);
      chk("arb_rsp", 64'(rsp_valid), 64'(eg));
      chk("arb_data", 64'(rsp_data), 64'(memf(eg[1] ? addr1 : addr0)));
      tick();
    end
    req = 2'b00;
    chk("hits_3", 64'(hit_count), 64'd5);

    // refill across the top of the address space
    f0 = fl_addr.size(); m0 = mem_log.size();
    rd(1, 15'h7FFE, 1'b0);
    check_fill(15'h7FFE, f0, m0);

    // flush beats a pending request
    flush = 1'b1; req[0] = 1'b1; addr0 = 15'h1006;
    #1;
    chk("flush_prio_gnt", 64'(gnt), 64'd0);
    z0 = wz_cnt;
    tick();
    flush = 1'b0;
    wait_gnt(n);
    chk("flush2_len", 64'(n), 64'd4096);
    chk("flush2_writes", 64'(wz_cnt - z0), 64'd4096);
    chk("gnt_after_flush2", 64'(gnt), 64'd1);
    get_rsp(0, 15'h1006, 1'b0);
    chk("hits_4", 64'(hit_count), 64'd5);
    chk("misses_4", 64'(miss_count), 64'd5);

    // reset in the middle of a refill
    addr0 = 15'h3000; req[0] = 1'b1;
    wait_gnt(n);
    chk("mid_gnt", 64'(gnt), 64'd1);
    tick();
    req = 2'b00;
    tick();
    tick();
    r0 = rsp_cnt;
    rst = 1'b1;
    tick();
    tick();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_we", 64'(arr_we), 64'd0);
    chk("mid_rst_hits", 64'(hit_count), 64'd0);
    chk("mid_rst_misses", 64'(miss_count), 64'd0);
    rst = 1'b0;
    #1;
    chk("reflush_we", 64'(arr_we), 64'd1);
    chk("reflush_idx0", 64'(arr_addr), 64'd0);
    chk("reflush_wdata", 64'(arr_wdata), 64'd0);
    repeat (20) tick();
    chk("reflush_idx20", 64'(arr_addr), 64'd20);
    chk("dropped_rsp", 64'(rsp_cnt - r0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
